// File: rtl/matmul_sequencer_if.sv
// Handshake/bus bundle between the matmul control sequencer and its datapath.
// Optional MATMUL_SEQ_PAUSE_EN adds the pause input.
interface matmul_sequencer_if #(
  parameter int ADDR_A_W = 12,
  parameter int ADDR_B_W = 6,
  parameter int CNT_W    = 16
);
  logic                start;
`ifdef MATMUL_SEQ_PAUSE_EN
  logic                pause;
`endif
  logic [ADDR_A_W-1:0] rom_a_addr;
  logic [ADDR_B_W-1:0] rom_b_addr;
  logic                acc_clr;
  logic                acc_en;
  logic                busy;
  logic                done;
  logic                done_pulse;
  logic [CNT_W-1:0]    cycle_count;

  modport master (
    input  start,
    output rom_a_addr, rom_b_addr, acc_clr, acc_en, busy, done, done_pulse,
    output cycle_count
`ifdef MATMUL_SEQ_PAUSE_EN
    , input pause
`endif
  );

  modport slave (
    output start,
    input  rom_a_addr, rom_b_addr, acc_clr, acc_en, busy, done, done_pulse,
    input  cycle_count
`ifdef MATMUL_SEQ_PAUSE_EN
    , output pause
`endif
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Control FSM for the ROM / multiplier / adder-tree matmul datapath.
// IDLE -> CLEAR -> RUN (STEPS addresses) -> DRAIN (ROM_LAT+ADD_LAT) -> DONE.
// acc_en is issue_valid delayed ROM_LAT cycles so it lines up with ROM data.
// Optional MATMUL_SEQ_PAUSE_EN: pause input stalls issue while in RUN.
module matmul_sequencer #(
  parameter int STEPS    = 64,
  parameter int ADDR_A_W = 12,
  parameter int ADDR_B_W = 6,
  parameter int ROM_LAT  = 1,
  parameter int ADD_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input logic clock,
  input logic reset_l,
  matmul_sequencer_if.master bus
);
  localparam int SW        = $clog2(STEPS + 1);
  localparam int DRAIN_CYC = ROM_LAT + ADD_LAT;
  localparam int DW        = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t           state_q;
  logic [SW-1:0]    step_q;
  logic [DW-1:0]    drain_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, done_pulse_q, acc_clr_q;
  logic [ROM_LAT-1:0] vld_pipe_q;

  logic             hold, issue_v, last_step;
  logic [CNT_W-1:0] cnt_inc;

`ifdef MATMUL_SEQ_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  assign issue_v   = (state_q == RUN) && !hold;
  assign last_step = (step_q == SW'(STEPS - 1));
  // Saturating increment: the display path must never see a wrapped count.
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Sequencer state, step/drain counters and all registered control outputs.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= IDLE;
      step_q       <= '0;
      drain_q      <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      acc_clr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_pulse_q <= 1'b0;
          if (bus.start) begin
            state_q   <= CLEAR;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            acc_clr_q <= 1'b1;
            cnt_q     <= CNT_W'(1);
            step_q    <= '0;
          end
        end
        CLEAR: begin
          state_q   <= RUN;
          acc_clr_q <= 1'b0;
          cnt_q     <= cnt_inc;
        end
        RUN: begin
          cnt_q <= cnt_inc;
          if (issue_v) begin
            if (last_step) begin
              state_q <= DRAIN;
              drain_q <= '0;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_q == DW'(DRAIN_CYC - 1)) begin
            // Count freezes here: the DONE cycle itself is not busy.
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            done_pulse_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
            cnt_q   <= cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Issue-valid delay line matching ROM read latency; reset discards in-flight bits.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= issue_v;
      for (int i = 1; i < ROM_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  assign bus.rom_a_addr  = ADDR_A_W'(step_q);
  assign bus.rom_b_addr  = ADDR_B_W'(step_q);
  assign bus.acc_clr     = acc_clr_q;
  assign bus.acc_en      = vld_pipe_q[ROM_LAT-1];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.done_pulse  = done_pulse_q;
  assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: three configurations
// (defaults, STEPS=1/ROM_LAT=2, CNT_W=4) checked every cycle against a
// timeline model keyed on cycles elapsed since the CLEAR cycle.
module tb_matmul_sequencer;
  logic clock = 1'b0;
  logic reset_l;
  always #5 clock = ~clock;

  matmul_sequencer_if #(.ADDR_A_W(12), .ADDR_B_W(6), .CNT_W(16)) bus0 ();
  matmul_sequencer_if #(.ADDR_A_W(12), .ADDR_B_W(6), .CNT_W(16)) bus1 ();
  matmul_sequencer_if #(.ADDR_A_W(12), .ADDR_B_W(6), .CNT_W(4))  bus2 ();

  matmul_sequencer #(.STEPS(64), .ADDR_A_W(12), .ADDR_B_W(6), .ROM_LAT(1), .ADD_LAT(1), .CNT_W(16))
    u0 (.clock(clock), .reset_l(reset_l), .bus(bus0));
  matmul_sequencer #(.STEPS(1), .ADDR_A_W(12), .ADDR_B_W(6), .ROM_LAT(2), .ADD_LAT(1), .CNT_W(16))
    u1 (.clock(clock), .reset_l(reset_l), .bus(bus1));
  matmul_sequencer #(.STEPS(64), .ADDR_A_W(12), .ADDR_B_W(6), .ROM_LAT(1), .ADD_LAT(1), .CNT_W(4))
    u2 (.clock(clock), .reset_l(reset_l), .bus(bus2));

  typedef struct {
    logic busy, done, dp, clr, en;
    logic [31:0] a, b, cnt;
  } obs_t;

  int P_STEPS[3] = '{64, 1, 64};
  int P_RL[3]    = '{1, 2, 1};
  int P_AL[3]    = '{1, 1, 1};
  int P_CW[3]    = '{16, 16, 4};

  int pass = 0, total = 0, fails = 0;
  int mcyc = 0;
  int t0[3];
  bit started[3];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) pass++;
    else begin
      fails++;
      $error("FAIL %s @cyc%0d obs=%0h exp=%0h", tag, mcyc, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    mcyc++;
  endtask

  task automatic sample(input int sel, output obs_t o);
    case (sel)
      0: begin o.busy = bus0.busy; o.done = bus0.done; o.dp = bus0.done_pulse; o.clr = bus0.acc_clr;
               o.en = bus0.acc_en; o.a = 32'(bus0.rom_a_addr); o.b = 32'(bus0.rom_b_addr);
               o.cnt = 32'(bus0.cycle_count); end
      1: begin o.busy = bus1.busy; o.done = bus1.done; o.dp = bus1.done_pulse; o.clr = bus1.acc_clr;
               o.en = bus1.acc_en; o.a = 32'(bus1.rom_a_addr); o.b = 32'(bus1.rom_b_addr);
               o.cnt = 32'(bus1.cycle_count); end
      default: begin o.busy = bus2.busy; o.done = bus2.done; o.dp = bus2.done_pulse; o.clr = bus2.acc_clr;
               o.en = bus2.acc_en; o.a = 32'(bus2.rom_a_addr); o.b = 32'(bus2.rom_b_addr);
               o.cnt = 32'(bus2.cycle_count); end
    endcase
  endtask

  // Expected outputs given cycles elapsed since the CLEAR cycle (rel=0).
  function automatic obs_t model(input int sel, input int rel, input bit st);
    obs_t e;
    int steps, last, av, cap;
    e.busy = 0; e.done = 0; e.dp = 0; e.clr = 0; e.en = 0; e.a = 0; e.b = 0; e.cnt = 0;
    if (!st) return e;
    steps = P_STEPS[sel];
    last  = steps + P_RL[sel] + P_AL[sel];
    cap   = (1 << P_CW[sel]) - 1;
    av    = (rel == 0) ? 0 : (rel <= steps) ? rel - 1 : steps - 1;
    e.busy = (rel <= last);
    e.clr  = (rel == 0);
    e.en   = (rel >= 1 + P_RL[sel]) && (rel <= steps + P_RL[sel]);
    e.done = (rel > last);
    e.dp   = (rel == last + 1);
    e.a    = 32'(av % 4096);
    e.b    = 32'(av % 64);
    e.cnt  = 32'((rel <= last) ? rel + 1 : last + 1);
    if (e.cnt > 32'(cap)) e.cnt = 32'(cap);
    return e;
  endfunction

  task automatic chk_all(input int sel);
    obs_t o, e;
    sample(sel, o);
    e = model(sel, mcyc - t0[sel], started[sel]);
    chk($sformatf("d%0d.busy", sel), 32'(o.busy), 32'(e.busy));
    chk($sformatf("d%0d.done", sel), 32'(o.done), 32'(e.done));
    chk($sformatf("d%0d.done_pulse", sel), 32'(o.dp), 32'(e.dp));
    chk($sformatf("d%0d.acc_clr", sel), 32'(o.clr), 32'(e.clr));
    chk($sformatf("d%0d.acc_en", sel), 32'(o.en), 32'(e.en));
    chk($sformatf("d%0d.rom_a_addr", sel), o.a, e.a);
    chk($sformatf("d%0d.rom_b_addr", sel), o.b, e.b);
    chk($sformatf("d%0d.cycle_count", sel), o.cnt, e.cnt);
  endtask

  // Drive start for one cycle on the selected DUT, advance a clock, check it.
  task automatic cyc_step(input int sel, input bit st);
    int rn, last;
    rn   = mcyc - t0[sel];
    last = P_STEPS[sel] + P_RL[sel] + P_AL[sel];
    if (st && reset_l && (!started[sel] || rn > last)) begin
      started[sel] = 1;
      t0[sel] = mcyc + 1;
    end
    bus0.start = (sel == 0) && st;
    bus1.start = (sel == 1) && st;
    bus2.start = (sel == 2) && st;
    tick();
    bus0.start = 0; bus1.start = 0; bus2.start = 0;
    chk_all(sel);
  endtask

  initial begin
    obs_t o;
    reset_l = 0;
    bus0.start = 0; bus1.start = 0; bus2.start = 0;
`ifdef MATMUL_SEQ_PAUSE_EN
    bus0.pause = 0; bus1.pause = 0; bus2.pause = 0;
`endif
    for (int s = 0; s < 3; s++) begin started[s] = 0; t0[s] = 0; end

    // Reset state on all three configurations
    tick(); tick();
    for (int s = 0; s < 3; s++) chk_all(s);
    reset_l = 1;

    // Single run on defaults, with stray start pulses while busy
    repeat ($urandom_range(2, 5)) cyc_step(0, 0);
    cyc_step(0, 1);
    for (int i = 0; i < 75; i++) cyc_step(0, $urandom_range(0, 7) == 0);
    repeat (5) cyc_step(0, 0);

    // Start held high: back-to-back runs
    for (int i = 0; i < 150; i++) cyc_step(0, 1);
    for (int i = 0; i < 75; i++) cyc_step(0, 0);

    // Asynchronous reset mid-RUN, then start on the first clock out of reset
    cyc_step(0, 1);
    for (int i = 0; i < 29; i++) cyc_step(0, 0);
    #2 reset_l = 0;
    #1;
    sample(0, o);
    chk("async_rst.busy", 32'(o.busy), 32'd0);
    chk("async_rst.acc_en", 32'(o.en), 32'd0);
    chk("async_rst.rom_a_addr", o.a, 32'd0);
    chk("async_rst.cycle_count", o.cnt, 32'd0);
    for (int s = 0; s < 3; s++) started[s] = 0;
    repeat (3) cyc_step(0, 0);
    reset_l = 1;
    cyc_step(0, 1);
    for (int i = 0; i < 75; i++) cyc_step(0, 0);

    // STEPS=1, ROM_LAT=2 configuration with random restarts
    cyc_step(1, 1);
    for (int i = 0; i < 60; i++) cyc_step(1, $urandom_range(0, 3) == 0);

    // CNT_W=4: saturating cycle count
    cyc_step(2, 1);
    for (int i = 0; i < 80; i++) cyc_step(2, 0);

`ifdef MATMUL_SEQ_PAUSE_EN
    // Pause for 10 cycles when step 20 is on the address bus
    begin
      int pleft = 0, en_cnt = 0;
      bit pdone = 0, got = 0;
      bus0.start = 1;
      tick();
      bus0.start = 0;
      for (int i = 0; i < 200 && !got; i++) begin
        tick();
        if (bus0.acc_en) en_cnt++;
        if (pleft > 0) begin
          chk("pause.addr_hold", 32'(bus0.rom_a_addr), 32'd20);
          pleft--;
          if (pleft == 0) bus0.pause = 0;
        end else if (!pdone && bus0.busy && bus0.rom_a_addr == 12'd20) begin
          bus0.pause = 1;
          pleft = 10;
          pdone = 1;
        end
        if (bus0.done_pulse) begin
          got = 1;
          chk("pause.cycle_count", 32'(bus0.cycle_count), 32'd77);
        end
      end
      chk("pause.done_seen", 32'(got), 32'd1);
      chk("pause.acc_en_count", 32'(en_cnt), 32'd64);
      bus0.pause = 0;
    end
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Control FSM for the dot-product / matrix-multiply datapath made of ROM banks, accumulating sum registers, a multiplier array and an adder tree.
- Takes a start request.
- Clears the accumulators, then issues one ROM address per cycle for STEPS cycles.
- Aligns the accumulate-enable with ROM read latency and drains the pipeline.
- Raises done together with a cycle count for the seven-segment display path.
- Replaces free-running address counters and self-timed done detection.

Parameters:
STEPS, 64, number of accumulate steps (ROM addresses issued per run); legal range >= 1
ADDR_A_W, 12, width of ROM A address output
ADDR_B_W, 6, width of ROM B address output
ROM_LAT, 1, ROM read latency in cycles, from address to q valid; legal range >= 1
ADD_LAT, 1, cycles from the last acc_en until final_sum is valid
CNT_W, 16, width of cycle_count

Ports:
clock  input  1  system clock, rising edge
reset_l  input  1  asynchronous active-low reset
start  input  1  run request; sampled high for one cycle
rom_a_addr  output  ADDR_A_W  ROM A base address; lanes add their own offsets
rom_b_addr  output  ADDR_B_W  ROM B base address
acc_clr  output  1  synchronous clear of all sum/B registers
acc_en  output  1  accumulate enable, aligned to ROM data
busy  output  1  high in CLEAR, RUN and DRAIN
done  output  1  level; high in DONE until the next start
done_pulse  output  1  one-cycle strobe on entry to DONE; drives the answer-capture register enable
cycle_count  output  CNT_W  cycles spent busy in the current or last run

Behaviour:
- Reset is asynchronous, active-low, on reset_l; clock is clock.
- On reset:
  - state = IDLE.
  - All outputs are 0, including rom_a_addr, rom_b_addr and cycle_count.
  - The issue pipeline is flushed.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: start=1 -> CLEAR.
- CLEAR (1 cycle):
  - acc_clr=1, cycle_count reset to 1.
  - step=0.
  - -> RUN.
- RUN (exactly STEPS cycles):
  - rom_a_addr = step, zero-extended or truncated to ADDR_A_W.
  - rom_b_addr = step mod 2^ADDR_B_W.
  - issue_valid=1.
  - step increments each cycle.
  - On the cycle with step == STEPS-1 -> DRAIN.
- acc_en = issue_valid delayed by ROM_LAT cycles through a shift register.
  - acc_en is therefore high for exactly STEPS consecutive cycles.
  - The first acc_en cycle is ROM_LAT cycles after the first RUN cycle.
- DRAIN (exactly ROM_LAT+ADD_LAT cycles):
  - Addresses hold their last value.
  - issue_valid=0.
  - -> DONE.
- DONE:
  - done=1.
  - done_pulse=1 on the first DONE cycle only.
  - cycle_count is frozen.
  - start=1 -> CLEAR (restart); done drops in the CLEAR cycle.
- cycle_count:
  - Increments by 1 every busy cycle.
  - Saturates at 2^CNT_W-1 and never wraps.
- start while busy is ignored; no queueing.
- start in IDLE and reset deasserting in the same cycle: start is honoured on the first clock with reset_l=1.
- Reset mid-run: immediate return to IDLE, outputs 0, pending acc_en bits discarded.
- STEPS=1: RUN lasts 1 cycle, acc_en pulses once.
- Addresses beyond the ROM width wrap modulo 2^width; no error is flagged.

Optional Feature:
MATMUL_SEQ_PAUSE_EN
- Defined:
  - Adds an input port pause (1 bit).
  - While pause=1 in RUN: step and the addresses hold, issue_valid=0, and cycle_count keeps counting.
  - The acc_en pipeline keeps shifting, so in-flight data still accumulates exactly once.
  - pause is ignored outside RUN.
- Not defined:
  - The port is absent.
  - RUN is always exactly STEPS cycles.

Test Plan:
- Defaults, start pulse at cycle 0:
  - acc_clr at cycle 1.
  - Addresses 0..63 on cycles 2..65.
  - acc_en on cycles 3..66.
  - done_pulse at cycle 68.
  - cycle_count = 67.
- start held high continuously:
  - Runs back-to-back.
  - Each DONE lasts 1 cycle, then CLEAR.
  - cycle_count returns to 1 at each CLEAR.
- reset_l low at cycle 30 mid-RUN:
  - All outputs 0 asynchronously.
  - No acc_en afterwards.
  - Next start gives a full 64-cycle run with cycle_count = 67.
- STEPS=1, ROM_LAT=2, ADD_LAT=1:
  - One address 0.
  - acc_en exactly once, 2 cycles after issue.
  - cycle_count = 5.
- CNT_W=4 with defaults: cycle_count saturates at 15 and holds in DONE.
- MATMUL_SEQ_PAUSE_EN, pause high for 10 cycles at step 20:
  - Addresses hold at 20.
  - acc_en count is still 64.
  - cycle_count = 77.
